// File: rtl/sr_cond_pkg.sv
// Shared types and limits for the SR input conditioner and its debounce channels.
package sr_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_DEBOUNCE    = 2;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser chain followed by a press/release debounce FSM.
// fire_o is high in the cycle whose closing edge moves the FSM into HELD.
module debounce_channel
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nReset,
  input  logic raw_i,
  output logic fire_o,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end
  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least %0d", MIN_DEBOUNCE);
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  deb_state_t             state_q, state_d;
  logic                   x_s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign x_s    = sync_q[SYNC_STAGES-1];

  // State, counter and synchroniser registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      cnt_q   <= CNT_ZERO;
      state_q <= IDLE;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Next state: any sample disagreeing with the pending change restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (x_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!x_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!x_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      RELEASE_WAIT: begin
        if (x_s) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    level_o = 1'b0;
    fire_o  = 1'b0;
    if ((state_q == HELD) || (state_q == RELEASE_WAIT)) begin
      level_o = 1'b1;
    end else begin
      level_o = 1'b0;
    end
    if ((state_q == PRESS_WAIT) && x_s && (cnt_q == CNT_MAX)) begin
      fire_o = 1'b1;
    end else begin
      fire_o = 1'b0;
    end
  end

endmodule

// File: rtl/sr_input_conditioner.sv
// Conditions the raw set/reset buttons into clean S/R pulses and debounced levels.
// Define SR_INTERLOCK_EN to suppress simultaneous S/R pulses and flag them on conflict.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nReset,
  input  logic set_async,
  input  logic rst_async,
  output logic S,
  output logic R,
  output logic set_level,
  output logic rst_level,
  output logic conflict
);

  logic set_fire_s, rst_fire_s;
  logic s_q, s_d, r_q, r_d, conflict_q, conflict_d;

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set (
    .clk    (clk),
    .nReset (nReset),
    .raw_i  (set_async),
    .fire_o (set_fire_s),
    .level_o(set_level)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rst (
    .clk    (clk),
    .nReset (nReset),
    .raw_i  (rst_async),
    .fire_o (rst_fire_s),
    .level_o(rst_level)
  );

  // Pulse interlock: both channels qualifying together blocks both pulses.
  always_comb begin
    s_d        = set_fire_s;
    r_d        = rst_fire_s;
    conflict_d = 1'b0;
`ifdef SR_INTERLOCK_EN
    if (set_fire_s && rst_fire_s) begin
      s_d        = 1'b0;
      r_d        = 1'b0;
      conflict_d = 1'b1;
    end else begin
      conflict_d = 1'b0;
    end
`endif
  end

  // Registered pulse outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Self-checking bench for sr_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_sr_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic set_async = 1'b0;
  logic rst_async = 1'b0;
  logic S, R, set_level, rst_level, conflict;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .nReset   (nReset),
    .set_async(set_async),
    .rst_async(rst_async),
    .S        (S),
    .R        (R),
    .set_level(set_level),
    .rst_level(rst_level),
    .conflict (conflict)
  );

  // Reference model: raw value history since reset, debounced level and run of
  // consecutive synced samples that disagree with that level.
  bit raw_hist [2][0:4095];
  int nedge;
  bit lvl [2];
  int run [2];
  bit m_S, m_R, m_conf;

  typedef struct {
    bit s_in;
    bit r_in;
    bit e_S;
    bit e_R;
    bit e_sl;
    bit e_rl;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    nedge  = 0;
    lvl[0] = 1'b0; lvl[1] = 1'b0;
    run[0] = 0;    run[1] = 0;
    m_S = 1'b0; m_R = 1'b0; m_conf = 1'b0;
  endtask

  task automatic model_edge(input bit s_in, input bit r_in);
    bit fire [2];
    bit x;
    raw_hist[0][nedge] = s_in;
    raw_hist[1][nedge] = r_in;
    for (int c = 0; c < 2; c++) begin
      x = (nedge >= SYNC) ? raw_hist[c][nedge-SYNC] : 1'b0;
      fire[c] = 1'b0;
      if (x != lvl[c]) begin
        run[c]++;
        if (run[c] == DEB) begin
          lvl[c]  = x;
          run[c]  = 0;
          fire[c] = x;
        end
      end else begin
        run[c] = 0;
      end
    end
    nedge++;
    m_S = fire[0];
    m_R = fire[1];
    m_conf = 1'b0;
`ifdef SR_INTERLOCK_EN
    if (fire[0] && fire[1]) begin
      m_S = 1'b0;
      m_R = 1'b0;
      m_conf = 1'b1;
    end
`endif
  endtask

  // Drive one cycle of inputs, advance one edge, compare against the model.
  task automatic step(input bit s_in, input bit r_in);
    set_async = s_in;
    rst_async = r_in;
    @(posedge clk);
    model_edge(s_in, r_in);
    #1;
    check("S", S, m_S);
    check("R", R, m_R);
    check("set_level", set_level, lvl[0]);
    check("rst_level", rst_level, lvl[1]);
    check("conflict", conflict, m_conf);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_S"}, S, 1'b0);
    check({tag, "_R"}, R, 1'b0);
    check({tag, "_set_level"}, set_level, 1'b0);
    check({tag, "_rst_level"}, rst_level, 1'b0);
    check({tag, "_conflict"}, conflict, 1'b0);
  endtask

  // Called just after a rising edge; reset pulse fits between two edges.
  task automatic do_reset();
    nReset = 1'b0;
    #1;
    check_all_zero("rst");
    #1;
    nReset = 1'b1;
    model_clear();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int np;
    int first;

    for (int i = 0; i < 8; i++) begin
      vecs[i].s_in = 1'b1;
      vecs[i].r_in = 1'b0;
      vecs[i].e_S  = (i == 5);
      vecs[i].e_R  = 1'b0;
      vecs[i].e_sl = (i >= 5);
      vecs[i].e_rl = 1'b0;
    end

    // Async reset with both buttons pressed, before any clock edge.
    set_async = 1'b1;
    rst_async = 1'b1;
    #2;
    check_all_zero("reset_no_clk");
    set_async = 1'b0;
    rst_async = 1'b0;
    #2;
    nReset = 1'b1;
    model_clear();
    idle_cycles(3);

    // Press latency from a table of constant expectations.
    foreach (vecs[i]) begin
      step(vecs[i].s_in, vecs[i].r_in);
      check("tbl_S", S, vecs[i].e_S);
      check("tbl_R", R, vecs[i].e_R);
      check("tbl_set_level", set_level, vecs[i].e_sl);
      check("tbl_rst_level", rst_level, vecs[i].e_rl);
    end
    idle_cycles(SYNC + DEB + 2);

    // Early bounce restarts the count: 1,1,0 then held high.
    np = 0;
    first = -1;
    for (int i = 0; i < 14; i++) begin
      step((i == 2) ? 1'b0 : 1'b1, 1'b0);
      if (S === 1'b1) begin
        np++;
        if (first < 0) first = i;
      end
    end
    check("bounce_pulse_count", (np == 1), 1'b1);
    check("bounce_pulse_index", (first == 8), 1'b1);

    // Short release glitch while held: no re-fire, level stays high.
    np = 0;
    for (int i = 0; i < 8; i++) begin
      step((i == 0) ? 1'b0 : 1'b1, 1'b0);
      check("glitch_level", set_level, 1'b1);
      if (S === 1'b1) np++;
    end
    check("glitch_no_refire", (np == 0), 1'b1);
    idle_cycles(SYNC + DEB);
    check("release_level", set_level, 1'b0);
    idle_cycles(2);

    // Simultaneous press on both channels.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      if (i == 5) begin
`ifdef SR_INTERLOCK_EN
        check("both_S", S, 1'b0);
        check("both_R", R, 1'b0);
        check("both_conflict", conflict, 1'b1);
`else
        check("both_S", S, 1'b1);
        check("both_R", R, 1'b1);
        check("both_conflict", conflict, 1'b0);
`endif
      end
    end
    check("both_set_level", set_level, 1'b1);
    check("both_rst_level", rst_level, 1'b1);
    idle_cycles(SYNC + DEB + 2);

    // Reset in the middle of a press count loses all progress.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    do_reset();
    first = -1;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0);
      if (S === 1'b1 && first < 0) first = i;
    end
    check("reset_restart_latency", (first == 5), 1'b1);
    idle_cycles(SYNC + DEB + 2);

    // Randomised buttons with mostly long holds, occasional resets.
    begin
      bit s_in, r_in;
      s_in = 1'b0;
      r_in = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 5) == 0) s_in = ~s_in;
        if ($urandom_range(0, 5) == 0) r_in = ~r_in;
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
        end
        step(s_in, r_in);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
